// File: rtl/mem_tag_responder.sv
// Tagged fixed-latency block read responder with a tag pool and backing store.
// MEM_RESPONDER_SINGLE_PORT_EN models a single-ported bank.
`ifndef NUM_MEM_TAGS
`define NUM_MEM_TAGS 15
`endif

module mem_tag_responder #(
  parameter int NUM_TAGS = `NUM_MEM_TAGS,
  parameter int LATENCY  = 4,
  parameter int DEPTH    = 256
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             req_valid,
  input  logic [31:0]                      req_addr,
  output logic                             req_accepted,
  output logic [$clog2(NUM_TAGS+1)-1:0]    req_tag,
  output logic [63:0]                      rsp_data,
  output logic [$clog2(NUM_TAGS+1)-1:0]    rsp_tag,
  input  logic                             load_en,
  input  logic [31:0]                      load_addr,
  input  logic [63:0]                      load_data
);

  localparam int TW = $clog2(NUM_TAGS + 1);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
  localparam int QD = 1 << PW;
  localparam logic [4:0] CD0 =
    (LATENCY > 1) ? 5'(LATENCY - 2) : 5'd0;

  logic [NUM_TAGS-1:0] free, free_nxt;
  logic [TW-1:0]       grant;
  logic                accept;
  logic                push;
  logic                q_pop;
  logic                pop;
  logic [TW-1:0]       pop_tag;
  logic [IW-1:0]       pop_idx;
  logic                load_we;
  logic [IW-1:0]       req_idx, load_idx;

  logic [TW-1:0]       q_tag [QD];
  logic [IW-1:0]       q_idx [QD];
  logic [4:0]          q_cd  [QD];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [TW-1:0]       q_cnt;

  logic [63:0]         mem [DEPTH];

  logic unused_addr;
  assign unused_addr = ^{req_addr[2:0], req_addr[31:IW+3],
                         load_addr[2:0], load_addr[31:IW+3]};

  assign req_idx  = req_addr[3 +: IW];
  assign load_idx = load_addr[3 +: IW];

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (32'(p) == NUM_TAGS - 1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    grant = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--)
      if (free[i]) grant = TW'(i + 1);
  end

  // Head entry is due when its countdown has reached zero.
  assign q_pop = (q_cnt != '0) && (q_cd[rd_ptr] == 5'd0);

`ifdef MEM_RESPONDER_SINGLE_PORT_EN
  assign accept  = reset && req_valid && (|free) && !q_pop;
`else
  assign accept  = reset && req_valid && (|free);
`endif

  assign req_accepted = accept;
  assign req_tag      = accept ? grant : '0;
  assign push         = accept && (LATENCY > 1);

  always_comb begin
    pop     = q_pop;
    pop_tag = q_tag[rd_ptr];
    pop_idx = q_idx[rd_ptr];
    if (LATENCY == 1) begin
      pop     = accept;
      pop_tag = grant;
      pop_idx = req_idx;
    end
  end

`ifdef MEM_RESPONDER_SINGLE_PORT_EN
  assign load_we = load_en && !pop;
`else
  assign load_we = load_en;
`endif

  // A tag comes back to the pool after the cycle its response is shown.
  always_comb begin
    free_nxt = free;
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (accept && grant == TW'(i + 1)) free_nxt[i] = 1'b0;
      if (rsp_tag == TW'(i + 1))         free_nxt[i] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      free     <= '1;
      rsp_tag  <= '0;
      rsp_data <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      q_cnt    <= '0;
    end else begin
      free     <= free_nxt;
      rsp_tag  <= pop ? pop_tag : '0;
      rsp_data <= pop ? mem[pop_idx] : '0;
      if (push)  wr_ptr <= nxt(wr_ptr);
      if (q_pop) rd_ptr <= nxt(rd_ptr);
      unique case ({push, q_pop})
        2'b10:   q_cnt <= q_cnt + 1'b1;
        2'b01:   q_cnt <= q_cnt - 1'b1;
        default: q_cnt <= q_cnt;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < QD; i++)
      if (q_cd[i] != 5'd0) q_cd[i] <= q_cd[i] - 5'd1;
    if (push) begin
      q_tag[wr_ptr] <= grant;
      q_idx[wr_ptr] <= req_idx;
      q_cd[wr_ptr]  <= CD0;
    end
  end

  always_ff @(posedge clock) begin
    if (load_we) mem[load_idx] <= load_data;
  end

endmodule

// File: tb/tb_mem_tag_responder.sv
// Directed bench for mem_tag_responder with three tags and latency 4.
// Expectations follow MEM_RESPONDER_SINGLE_PORT_EN when it is defined.
module tb_mem_tag_responder;

  localparam int TW = 2;
  localparam logic [63:0] A5 = 64'hDEAD_BEEF_0000_0005;
  localparam logic [63:0] A7 = 64'h1111_2222_3333_0007;
  localparam logic [63:0] B7 = 64'h4444_5555_6666_0007;
  localparam logic [63:0] C1 = 64'h7777_8888_9999_0001;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic [31:0]   req_addr = '0;
  logic          req_accepted;
  logic [TW-1:0] req_tag;
  logic [63:0]   rsp_data;
  logic [TW-1:0] rsp_tag;
  logic          load_en = 1'b0;
  logic [31:0]   load_addr = '0;
  logic [63:0]   load_data = '0;

  int checks = 0;
  int failures = 0;

  mem_tag_responder #(
    .NUM_TAGS(3),
    .LATENCY (4),
    .DEPTH   (256)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_accepted(req_accepted),
    .req_tag     (req_tag),
    .rsp_data    (rsp_data),
    .rsp_tag     (rsp_tag),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int sat_tag [6];
    int sat_rsp [6];
    logic [63:0] late7;
`ifdef MEM_RESPONDER_SINGLE_PORT_EN
    sat_tag = '{1, 2, 3, 0, 0, 0};
    late7   = A7;
`else
    sat_tag = '{1, 2, 3, 0, 0, 1};
    late7   = B7;
`endif
    sat_rsp = '{0, 0, 0, 0, 1, 2};

    req_valid = 1'b1;
    req_addr  = 32'h28;
    #2;
    chk("rst_acc", 64'(req_accepted), 64'd0);
    chk("rst_tag", 64'(req_tag), 64'd0);
    chk("rst_rsp_tag", 64'(rsp_tag), 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    tick();
    tick();
    req_valid = 1'b0;
    reset     = 1'b1;
    tick();

    load_en = 1'b1; load_addr = 32'h28; load_data = A5;
    tick();
    load_en = 1'b0;
    req_valid = 1'b1; req_addr = 32'h28;
    #1;
    chk("t1_acc", 64'(req_accepted), 64'd1);
    chk("t1_tag", 64'(req_tag), 64'd1);
    tick();
    req_valid = 1'b0;
    #1 chk("t1_c1_rsp", 64'(rsp_tag), 64'd0);
    tick();
    tick();
    #1 chk("t1_c3_rsp", 64'(rsp_tag), 64'd0);
    tick();
    #1;
    chk("t1_c4_tag", 64'(rsp_tag), 64'd1);
    chk("t1_c4_data", rsp_data, A5);
    tick();
    #1;
    chk("t1_c5_tag", 64'(rsp_tag), 64'd0);
    chk("t1_c5_data", rsp_data, 64'd0);

    for (int d = 0; d < 6; d++) begin
      tick();
      req_valid = 1'b1; req_addr = 32'h28;
      #1;
      chk($sformatf("sat_acc%0d", d), 64'(req_accepted),
          64'(sat_tag[d] != 0));
      chk($sformatf("sat_tag%0d", d), 64'(req_tag), 64'(sat_tag[d]));
      chk($sformatf("sat_rsp%0d", d), 64'(rsp_tag), 64'(sat_rsp[d]));
    end
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();

    load_en = 1'b1; load_addr = 32'h38; load_data = A7;
    tick();
    load_en = 1'b0;
    req_valid = 1'b1; req_addr = 32'h38;
    #1 chk("rbw_tag", 64'(req_tag), 64'd1);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    load_en = 1'b1; load_addr = 32'h38; load_data = B7;
    tick();
    load_en = 1'b0;
    #1;
    chk("rbw_rsp_tag", 64'(rsp_tag), 64'd1);
    chk("rbw_old_data", rsp_data, A7);
    tick();
    req_valid = 1'b1; req_addr = 32'h38;
    #1 chk("rbw2_tag", 64'(req_tag), 64'd1);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    #1 chk("rbw2_data", rsp_data, late7);

    tick();
    load_en = 1'b1; load_addr = 32'h08; load_data = C1;
    tick();
    load_en = 1'b0;
    req_valid = 1'b1; req_addr = 32'h808;
    #1 chk("wrap_tag", 64'(req_tag), 64'd1);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    #1;
    chk("wrap_rsp_tag", 64'(rsp_tag), 64'd1);
    chk("wrap_data", rsp_data, C1);

    tick();
    tick();
    req_valid = 1'b1; req_addr = 32'h28;
    #1 chk("mr_h0_tag", 64'(req_tag), 64'd1);
    tick();
    #1 chk("mr_h1_tag", 64'(req_tag), 64'd2);
    tick();
    reset = 1'b0;
    #1;
    chk("mr_h2_acc", 64'(req_accepted), 64'd0);
    chk("mr_h2_rsp", 64'(rsp_tag), 64'd0);
    tick();
    reset = 1'b1;
    req_valid = 1'b0;
    #1 chk("mr_h3_rsp", 64'(rsp_tag), 64'd0);
    tick();
    req_valid = 1'b1; req_addr = 32'h38;
    #1;
    chk("mr_h4_tag", 64'(req_tag), 64'd1);
    chk("mr_h4_rsp", 64'(rsp_tag), 64'd0);
    tick();
    req_valid = 1'b0;
    #1 chk("mr_h5_rsp", 64'(rsp_tag), 64'd0);
    tick();
    #1 chk("mr_h6_rsp", 64'(rsp_tag), 64'd0);
    tick();
    #1 chk("mr_h7_rsp", 64'(rsp_tag), 64'd0);
    tick();
    #1;
    chk("mr_h8_rsp", 64'(rsp_tag), 64'd1);
    chk("mr_h8_data", rsp_data, late7);

    tick();
    tick();
    req_valid = 1'b1; req_addr = 32'h28;
    #1 chk("sp_k0_tag", 64'(req_tag), 64'd1);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    req_valid = 1'b1;
    #1;
`ifdef MEM_RESPONDER_SINGLE_PORT_EN
    chk("sp_k3_acc", 64'(req_accepted), 64'd0);
    chk("sp_k3_tag", 64'(req_tag), 64'd0);
`else
    chk("sp_k3_acc", 64'(req_accepted), 64'd1);
    chk("sp_k3_tag", 64'(req_tag), 64'd2);
`endif
    tick();
    #1;
    chk("sp_k4_rsp", 64'(rsp_tag), 64'd1);
`ifdef MEM_RESPONDER_SINGLE_PORT_EN
    chk("sp_k4_tag", 64'(req_tag), 64'd2);
`else
    chk("sp_k4_tag", 64'(req_tag), 64'd3);
`endif
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
